// File: rtl/start_seq_pkg.sv
// Shared constants and types for the start-strobe sequencer: register map,
// control/status bit positions and the sequencer state encoding.
package start_seq_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DELAY  = 2'd1;
    localparam logic [1:0] ADDR_WIDTH  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int GO     = 0;
    localparam int ABORT  = 1;
    localparam int IRQ_EN = 2;

    // STATUS bit positions
    localparam int BUSY    = 0;
    localparam int DONE    = 1;
    localparam int TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PULSE,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/start_seq_downcnt.sv
// Loadable down-counter shared by the delay, pulse-width and timeout phases.
// Load has priority over decrement; the count saturates at zero.
module start_seq_downcnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/start_seq_ctrl.sv
// Avalon-MM controlled start-strobe sequencer: wait DELAY cycles, drive
// start_out for WIDTH cycles, then wait for done_in or a timeout.
module start_seq_ctrl
    import start_seq_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        done_in,
    output logic        start_out,
    output logic        irq
);

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] width_q;
    logic             irq_en_q;
    logic             done_q;
    logic             timeout_q;

    logic             wr_en;
    logic             ctrl_wr;
    logic             go_req;
    logic             abort_req;
    logic             done_clr;
    logic             timeout_clr;
    logic [CNT_W-1:0] width_m1;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             start_d;
    logic             done_set;
    logic             timeout_set;

    logic             unused_wdata;

    assign wr_en       = chipselect & ~write_n;
    assign ctrl_wr     = wr_en && (address == ADDR_CTRL);
    assign abort_req   = ctrl_wr & writedata[ABORT];
    // ABORT dominates GO when both arrive in one write
    assign go_req      = ctrl_wr & writedata[GO] & ~writedata[ABORT];
    assign done_clr    = wr_en && (address == ADDR_STATUS) && writedata[DONE];
    assign timeout_clr = wr_en && (address == ADDR_STATUS) && writedata[TIMEOUT];
    assign width_m1    = (width_q == '0) ? '0 : width_q - CNT_W'(1);

    assign unused_wdata = ^writedata;

    start_seq_downcnt #(
        .CNT_W (CNT_W)
    ) u_downcnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (go_req) state_d = ARM;
            ARM:       if (abort_req) state_d = IDLE;
                       else if (cnt_zero) state_d = PULSE;
            PULSE:     if (abort_req) state_d = IDLE;
                       else if (cnt_zero) state_d = WAIT_DONE;
            WAIT_DONE: if (abort_req || done_in || cnt_zero) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        start_d      = 1'b0;
        done_set     = 1'b0;
        timeout_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_req) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = delay_q;
                end
            end
            ARM: begin
                if (!abort_req) begin
                    if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = width_m1;
                        start_d      = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (!abort_req) begin
                    if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = TIMEOUT_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                        start_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                // done_in outranks the timeout terminal count
                if (!abort_req) begin
                    if (done_in) begin
                        done_set = 1'b1;
                    end else if (cnt_zero) begin
                        timeout_set = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_out <= 1'b0;
        end else begin
            start_out <= start_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            delay_q  <= '0;
            width_q  <= CNT_W'(1);
            irq_en_q <= 1'b0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL:  irq_en_q <= writedata[IRQ_EN];
                ADDR_DELAY: delay_q  <= writedata[CNT_W-1:0];
                ADDR_WIDTH: width_q  <= writedata[CNT_W-1:0];
                default:    ;
            endcase
        end
    end

    // Hardware set beats a same-cycle W1C clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            irq       <= 1'b0;
        end else begin
            done_q    <= done_set | (done_q & ~done_clr);
            timeout_q <= timeout_set | (timeout_q & ~timeout_clr);
            irq       <= irq_en_q & (done_q | timeout_q);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata[IRQ_EN] = irq_en_q;
            ADDR_DELAY:  readdata[CNT_W-1:0] = delay_q;
            ADDR_WIDTH:  readdata[CNT_W-1:0] = width_q;
            ADDR_STATUS: begin
                readdata[BUSY]    = (state_q != IDLE);
                readdata[DONE]    = done_q;
                readdata[TIMEOUT] = timeout_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_start_seq_ctrl.sv
// Randomized bench for start_seq_ctrl: expected strobe pulses are queued from
// edge arithmetic and a monitor compares each observed pulse against them.
module tb_start_seq_ctrl;
    import start_seq_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        done_in;
    logic        start_out;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic m_irq_en = 1'b0;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t exp_q[$];

    start_seq_ctrl #(
        .CNT_W          (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .done_in    (done_in),
        .start_out  (start_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Pulse monitor: a rising start_out marks the edge, the fall closes the pulse.
    int     rise_cyc = 0;
    logic   prev_start = 1'b0;
    pulse_t got_p;
    always @(posedge clk) begin
        #1;
        if (start_out === 1'b1 && prev_start !== 1'b1) rise_cyc = cyc;
        if (start_out !== 1'b1 && prev_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pulse_unexpected: rise edge %0d width %0d, none queued",
                         rise_cyc, cyc - rise_cyc);
            end else begin
                got_p = exp_q.pop_front();
                check("pulse_rise", rise_cyc, got_p.rise);
                check("pulse_width", cyc - rise_cyc, got_p.width);
            end
        end
        prev_start = start_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive(a, d);
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    function automatic logic [31:0] ctrl_word(input logic go, input logic ab);
        logic [31:0] r;
        r         = '0;
        r[GO]     = go;
        r[ABORT]  = ab;
        r[IRQ_EN] = m_irq_en;
        return r;
    endfunction

    // One GO sequence. k: done_in is sampled high k edges after the pulse falls
    // (k > T means never). abort_off: ABORT lands abort_off edges after GO.
    task automatic run_seq(input int d, input int w, input int k, input bit regos,
                           input int abort_off, input bit w1c_col);
        int          n, r, wp, f, e;
        bit          to, dn;
        logic [31:0] v;
        pulse_t      p;
        wr(ADDR_DELAY, 32'(d));
        wr(ADDR_WIDTH, 32'(w));
        wp = (w == 0) ? 1 : w;
        wr(ADDR_CTRL, ctrl_word(1'b1, 1'b0));
        n = cyc;
        r = n + 1 + d;
        f = r + wp;
        if (abort_off > 0) begin
            e  = n + abort_off;
            to = 1'b0;
            dn = 1'b0;
            if (e > r) begin
                p.rise  = r;
                p.width = (e < f) ? e - r : wp;
                exp_q.push_back(p);
            end
        end else begin
            p.rise  = r;
            p.width = wp;
            exp_q.push_back(p);
            dn = (k <= T);
            to = !dn;
            e  = dn ? f + k : f + T;
        end
        while (cyc < e) begin
            chipselect = 1'b0;
            write_n    = 1'b1;
            done_in    = 1'b0;
            if (cyc == n + 1) begin
                rd(ADDR_STATUS, v);
                check("status_busy_early", v, 32'h1);
            end
            if (cyc == e - 1) begin
                rd(ADDR_STATUS, v);
                check("status_before_end", v, 32'h1);
            end
            if (cyc + 1 <= f) done_in = 1'($urandom_range(0, 1));
            else if (cyc + 1 == f + k) done_in = 1'b1;
            if (regos && cyc + 1 == n + 2) drive(ADDR_CTRL, ctrl_word(1'b1, 1'b0));
            if (abort_off > 0 && cyc + 1 == e)
                drive(ADDR_CTRL, ctrl_word(1'($urandom_range(0, 1)), 1'b1));
            if (w1c_col && cyc + 1 == e) drive(ADDR_STATUS, 32'h2);
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        done_in    = 1'b0;
        rd(ADDR_STATUS, v);
        check("status_at_end", v, {29'b0, to, dn, 1'b0});
        check("irq_at_end", 32'(irq), 32'h0);
        tick();
        check("irq_after_end", 32'(irq), 32'(m_irq_en & (to | dn)));
        wr(ADDR_STATUS, 32'h6);
        rd(ADDR_STATUS, v);
        check("status_cleared", v, 32'h0);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        done_in    = 1'b0;
        tick();
        tick();
        check("rst_start_out", 32'(start_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd(ADDR_DELAY, v);  check("rst_delay", v, 32'h0);
        rd(ADDR_WIDTH, v);  check("rst_width", v, 32'h1);
        rd(ADDR_STATUS, v); check("rst_status", v, 32'h0);
        rd(ADDR_CTRL, v);   check("rst_ctrl", v, 32'h0);
        reset_n = 1'b1;
        tick();

        wr(ADDR_DELAY, 32'hABCD_0005);
        wr(ADDR_WIDTH, 32'h0000_0003);
        rd(ADDR_DELAY, v); check("rb_delay", v, 32'h5);
        rd(ADDR_WIDTH, v); check("rb_width", v, 32'h3);
        m_irq_en = 1'b1;
        wr(ADDR_CTRL, ctrl_word(1'b0, 1'b0));
        rd(ADDR_CTRL, v); check("rb_ctrl_irq_en", v, 32'h4);
        m_irq_en = 1'b0;
        wr(ADDR_CTRL, ctrl_word(1'b0, 1'b0));
        rd(ADDR_CTRL, v); check("rb_ctrl_clear", v, 32'h0);

        run_seq(5, 3, 4, 1'b0, 0, 1'b0);       // basic sequence, done_in
        run_seq(0, 0, 2, 1'b0, 0, 1'b0);       // zero delay and width
        m_irq_en = 1'b1;
        run_seq(1, 2, T + 5, 1'b0, 0, 1'b0);   // timeout with irq
        run_seq(2, 5, T + 5, 1'b0, 4, 1'b0);   // abort mid-pulse
        run_seq(4, 2, 3, 1'b1, 0, 1'b0);       // GO during ARM ignored
        run_seq(1, 1, T, 1'b0, 0, 1'b0);       // done on timeout terminal cycle
        run_seq(0, 2, 3, 1'b0, 0, 1'b1);       // W1C collides with done set

        // GO and ABORT together in IDLE must not start anything
        wr(ADDR_CTRL, ctrl_word(1'b1, 1'b1));
        rd(ADDR_STATUS, v); check("goabort_idle", v, 32'h0);
        tick();
        rd(ADDR_STATUS, v); check("goabort_idle_later", v, 32'h0);

        for (int i = 0; i < 20; i++) begin
            m_irq_en = 1'($urandom_range(0, 1));
            run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, T + 3)), 1'b0, 0, 1'b0);
        end

        // Reset while in ARM returns everything to reset values
        m_irq_en = 1'b1;
        wr(ADDR_DELAY, 32'd6);
        wr(ADDR_WIDTH, 32'd2);
        wr(ADDR_CTRL, ctrl_word(1'b1, 1'b0));
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check("midrst_start_out", 32'(start_out), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        rd(ADDR_STATUS, v); check("midrst_status", v, 32'h0);
        rd(ADDR_CTRL, v);   check("midrst_ctrl", v, 32'h0);
        rd(ADDR_DELAY, v);  check("midrst_delay", v, 32'h0);
        rd(ADDR_WIDTH, v);  check("midrst_width", v, 32'h1);
        reset_n = 1'b1;
        repeat (12) tick();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("start_out_idle", 32'(start_out), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/start_seq_ctrl.md
Name: start_seq_ctrl

Overview:
- Avalon-MM slave controller that sequences the single-bit start strobe into a downstream datapath.
- Software programs a delay and a pulse width, then issues GO. The block waits the delay, drives start_out for the programmed width, then waits for done_in or a timeout.
- Reports busy/done/timeout status and raises an interrupt.
- Replaces the bare PIO start bit when the strobe must be timed precisely and completion tracked in hardware.

Parameters:
- CNT_W, 16, width of the DELAY and WIDTH registers and the internal down-counter.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_DONE before the timeout is flagged (must be at least 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero wait states.
- done_in  in  1  completion level/pulse from the datapath.
- start_out  out  1  registered start strobe to the datapath.
- irq  out  1  interrupt, level.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on reset_n; when it is sampled low at a clk edge:
  - state=IDLE, start_out=0, irq=0.
  - DELAY=0, WIDTH=1, irq_en=0, done=0, timeout=0, counter=0.
- Register map (a write is chipselect & ~write_n):
  - addr 0 CTRL, write: bit0 GO, bit1 ABORT, bit2 irq_en (stored). Read: {29'b0, irq_en, 2'b0}.
  - addr 1 DELAY, R/W, bits CNT_W-1:0; upper bits ignored on write, read as 0.
  - addr 2 WIDTH, R/W, bits CNT_W-1:0. A value of 0 behaves as 1.
  - addr 3 STATUS: bit0 busy (RO, state!=IDLE), bit1 done (W1C), bit2 timeout (W1C). Other bits read 0.
- FSM states: IDLE, ARM, PULSE, WAIT_DONE.
  - IDLE: a GO write accepted at edge N loads counter=DELAY and enters ARM. GO clears neither done nor timeout.
  - ARM: if counter==0, load counter=max(WIDTH,1)-1, go to PULSE, set start_out=1. Otherwise decrement.
  - Timing result: start_out rises at edge N+1+DELAY and stays high exactly max(WIDTH,1) cycles.
  - PULSE: if counter==0, clear start_out, load counter=TIMEOUT_CYCLES-1, go to WAIT_DONE. Otherwise decrement.
  - WAIT_DONE: done_in sampled high sets done=1 and returns to IDLE. Otherwise, counter==0 sets timeout=1 and returns to IDLE. Otherwise decrement.
  - done_in is ignored in every state except WAIT_DONE.
- GO while busy: ignored; no restart and no error flag.
- ABORT in any non-IDLE state: next edge gives IDLE and start_out=0; done and timeout unchanged. ABORT in IDLE has no effect.
- GO and ABORT in the same write: ABORT wins.
- done_in and the timeout terminal count in the same cycle: done wins; timeout is not set.
- A W1C clear in the same cycle the hardware sets the bit: the set wins.
- DELAY/WIDTH writes while busy update the registers only; the current sequence uses its already-loaded counter. WIDTH is captured at the ARM→PULSE transition.
- irq is registered: irq = irq_en & (done | timeout), updated each edge. It rises one cycle after the status bit sets.
- readdata does not depend on chipselect and has no read side effects.
- Reset mid-sequence aborts immediately: all outputs take their reset values at that edge.

Decomposition:
- Package start_seq_pkg holds:
  - address constants ADDR_CTRL=0, ADDR_DELAY=1, ADDR_WIDTH=2, ADDR_STATUS=3.
  - CTRL bit indices GO=0, ABORT=1, IRQ_EN=2.
  - STATUS bit indices BUSY=0, DONE=1, TIMEOUT=2.
  - state enum typedef state_t {IDLE, ARM, PULSE, WAIT_DONE}.
- Register file and FSM live in one module.
- Optional sub-module start_seq_downcnt: loadable CNT_W-bit down-counter with load, decrement and zero flag, shared by the ARM, PULSE and WAIT_DONE phases.

Test Plan:
- Reset and readback: hold reset_n low for 2 edges → start_out=0, irq=0, read DELAY=0, WIDTH=1, STATUS=0. Write DELAY=5, WIDTH=3 → reads return 5 and 3.
- Basic sequence: DELAY=5, WIDTH=3, GO at edge N, done_in pulsed 4 cycles after the pulse ends → start_out high at edges N+6..N+8 only. STATUS reads busy=1 during the sequence, then done=1, busy=0.
- Zero values: DELAY=0, WIDTH=0, GO at edge N → start_out high for exactly 1 cycle from edge N+1.
- Timeout and irq: TIMEOUT_CYCLES=8, irq_en=1, done_in held 0 → timeout=1 exactly 8 cycles after the pulse falls, irq=1 one cycle later. Write 0x4 to STATUS → timeout=0, irq=0 next cycle.
- Abort and collisions:
  - ABORT mid-PULSE → start_out=0 and busy=0 next edge; done=0.
  - A GO issued while in ARM is ignored.
  - GO|ABORT written together in IDLE → stays IDLE.
- Simultaneous events:
  - done_in high on the timeout terminal cycle → done=1, timeout=0.
  - W1C of done in the same cycle done sets → done stays 1.
  - reset_n low mid-ARM → IDLE with all registers at reset values.
